dm_port_arbiter: RTL and testbench

- Shares the single-port, synchronous-read data memory between the CPU MEM stage (LOAD/STORE) and an external host/debug port (program/data loader, memory inspection).
- The CPU has priority. A host-wait counter guarantees the host a forced slot, during which the CPU is stalled.
- Sits between the MEM-stage signals (store enable, ALU address, register data) and the data memory. Drives cpu_stall into the PC/pipeline-register enable logic, alongside the load-use bubble.

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_arb_stats.sv | 35 +++
 rtl/dm_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   - owner_e : which requester owns the read in flight (returned next cycle)
//   - AW_DEF / DW_DEF : default address / data widths
//   - WAIT_W  : width of the host-wait counter
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_HOST = 2'b10
  } owner_e;

endpackage

// File: rtl/dm_arb_stats.sv
// -----------------------------------------------------------------------------
// dm_arb_stats
// Two 16-bit saturating event counters for the data-memory arbiter. The top
// instantiates this block only when built with DM_ARB_STATS_EN.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous, active-high reset (counters clear to 0)
//   stall     in   CPU stalled this cycle
//   host_gnt  in   host granted this cycle
//   stall_cnt out  number of stalled cycles, saturates at 16'hFFFF
//   host_cnt  out  number of host grants, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module dm_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        host_gnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] host_cnt
);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      host_cnt  <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (host_gnt && host_cnt != 16'hFFFF) host_cnt <= host_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Shares one single-port, synchronous-read data memory between the CPU MEM
// stage and an external host/debug port. The CPU wins by default; a host that
// has been denied HOST_WAIT_MAX consecutive cycles gets a forced slot and the
// CPU is stalled for that one cycle. Read data returns one cycle after the
// grant and is steered to its owner by a small read tracker.
//
// Optional build macro: DM_ARB_STATS_EN (adds live stall/host-grant counters;
// without it stall_cnt/host_cnt are tied to 0).
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata            CPU access request (held while stalled)
//   cpu_stall                        CPU access not performed this cycle
//   cpu_rvalid/cpu_rdata             CPU load data return (1-cycle latency)
//   host_req/we/addr/wdata           host access request (held until gnt)
//   host_gnt                         host access performed this cycle
//   host_rvalid/host_rdata           host read data return (1-cycle latency)
//   mem_en/we/addr/wdata, mem_rdata  data memory port
//   stall_cnt, host_cnt              statistics counters
// -----------------------------------------------------------------------------
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int HOST_WAIT_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   host_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_WAIT_MAX);

  logic [WAIT_W-1:0] wait_cnt;
  owner_e            rd_owner;
  owner_e            rd_owner_nxt;
  logic              cpu_win;
  logic              host_win;

  // ---------------------------------------------------------------------------
  // Grant decision. Both grants are held low while rst is high so that the
  // memory strobe and handshakes stay quiet during reset.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (!rst) begin
      if (host_req && wait_cnt == WAIT_MAX) host_win = 1'b1;  // forced slot
      else if (cpu_req)                     cpu_win  = 1'b1;
      else if (host_req)                    host_win = 1'b1;
    end
  end

  assign cpu_stall = cpu_req & host_win;
  assign host_gnt  = host_win;

  // ---------------------------------------------------------------------------
  // Memory bus mux; idle bus drives zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = cpu_win | host_win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_win) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read tracker: remember who issued this cycle's read so next cycle's
  // mem_rdata is flagged to the right requester. Writes leave no owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (host_win && !host_we)     rd_owner_nxt = OWN_HOST;
    else if (cpu_win && !cpu_we)  rd_owner_nxt = OWN_CPU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_nxt;
      // Counts consecutive denied host cycles; any grant or idle host clears it.
      if (!host_req || host_win)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign cpu_rvalid  = (rd_owner == OWN_CPU);
  assign host_rvalid = (rd_owner == OWN_HOST);
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

  // ---------------------------------------------------------------------------
  // Optional statistics.
  // ---------------------------------------------------------------------------
`ifdef DM_ARB_STATS_EN
  dm_arb_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .stall     (cpu_stall),
    .host_gnt  (host_gnt),
    .stall_cnt (stall_cnt),
    .host_cnt  (host_cnt)
  );
`else
  assign stall_cnt = 16'h0;
  assign host_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Self-checking bench for dm_port_arbiter. A behavioural memory sits on the
// mem_* port. A reference model tracks how long the host has been kept
// waiting, the expected memory contents and the outstanding read, and predicts
// every output each cycle. Directed scenarios are followed by constrained
// random traffic that obeys the hold rules of both requesters.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int AW            = 8;
  localparam int DW            = 8;
  localparam int HOST_WAIT_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   stall_cnt, host_cnt;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .AW            (AW),
    .DW            (DW),
    .HOST_WAIT_MAX (HOST_WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall_cnt   (stall_cnt),
    .host_cnt    (host_cnt)
  );

  // Synchronous-read single-port memory.
  logic [DW-1:0] ram [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] shadow [0:255] = '{default: '0};
  int            host_waited = 0;   // consecutive cycles the host was refused
  bit            pend_cpu    = 1'b0;
  bit            pend_host   = 1'b0;
  logic [DW-1:0] pend_data   = '0;
  bit            last_stall  = 1'b0;
  bit            last_hgnt   = 1'b0;
  int            obs_wait    = 0;   // DUT-observed consecutive host refusals
  int            obs_wait_max = 0;

  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // then advance the model across the rising edge.
  task automatic step();
    bit            e_host, e_cpu, e_stall, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    if (rst) begin
      pend_cpu    = 1'b0;
      pend_host   = 1'b0;
      host_waited = 0;
    end
    chk("cpu_rvalid",  32'(cpu_rvalid),  32'(pend_cpu));
    chk("host_rvalid", 32'(host_rvalid), 32'(pend_host));
    if (pend_cpu)  chk("cpu_rdata",  32'(cpu_rdata),  32'(pend_data));
    if (pend_host) chk("host_rdata", 32'(host_rdata), 32'(pend_data));

    // Host wins when it has waited its full quota or the CPU is idle.
    e_host  = !rst && host_req && (host_waited >= HOST_WAIT_MAX || !cpu_req);
    e_cpu   = !rst && cpu_req && !e_host;
    e_stall = e_host && cpu_req;
    e_en    = e_host || e_cpu;
    e_we    = e_host ? host_we    : (e_cpu ? cpu_we    : 1'b0);
    e_addr  = e_host ? host_addr  : (e_cpu ? cpu_addr  : '0);
    e_wd    = e_host ? host_wdata : (e_cpu ? cpu_wdata : '0);

    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("host_gnt",  32'(host_gnt),  32'(e_host));
    chk("mem_en",    32'(mem_en),    32'(e_en));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));

    if (host_req && !host_gnt && !rst) obs_wait++;
    else                               obs_wait = 0;
    if (obs_wait > obs_wait_max) obs_wait_max = obs_wait;

    pend_cpu  = e_cpu  && !cpu_we;
    pend_host = e_host && !host_we;
    if (pend_cpu || pend_host) pend_data = shadow[e_addr];
    if (e_en && e_we) shadow[e_addr] = e_wd;
    if (!rst) begin
      if (host_req && !e_host)
        host_waited = (host_waited < HOST_WAIT_MAX) ? host_waited + 1 : host_waited;
      else
        host_waited = 0;
    end
    last_stall = e_stall;
    last_hgnt  = e_host;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20; host_wdata = '0;

    // Reset with both requesters active: everything must stay quiet.
    repeat (2) step();
    rst = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    step();

    // Host only: preload 0x10 <= A5, write 0x20 <= 3C, read 0x20 back.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
    step();
    host_addr = 8'h20; host_wdata = 8'h3C;
    step();
    host_we = 1'b0;
    step();
    host_req = 1'b0;
    step();
    chk("host_read_data_3c", 32'(host_rdata), 32'h3C);

    // CPU only: load from 0x10 returns A5 one cycle later.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();
    cpu_req = 1'b0;
    step();
    chk("cpu_read_data_a5", 32'(cpu_rdata), 32'hA5);

    // Full contention for 12 cycles from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    repeat (12) step();
`ifdef DM_ARB_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
    chk("host_cnt",  32'(host_cnt),  32'd3);
`else
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
    chk("host_cnt",  32'(host_cnt),  32'd0);
`endif

    // Host drops after 2 refused cycles; next contention waits the full quota.
    repeat (2) step();
    host_req = 1'b0;
    step();
    host_req = 1'b1;
    repeat (5) step();

    // Reset while a CPU read is in flight: no rvalid may follow.
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    step();
    rst = 1'b1; cpu_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Constrained random traffic honouring both hold rules.
    for (int i = 0; i < 400; i++) begin
      if (!(cpu_req && last_stall)) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end
      if (!(host_req && !last_hgnt)) begin
        host_req   = 1'($urandom_range(0, 1));
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = AW'($urandom_range(0, 15));
        host_wdata = DW'($urandom);
      end
      step();
    end
    cpu_req = 1'b0; host_req = 1'b0;
    step();

    chk("starvation_bound", 32'(obs_wait_max <= HOST_WAIT_MAX), 32'd1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
